// File: rtl/bus_arbiter4_rr.sv
// Round-robin owner sequencer for the shared 4-source tri-state data line.
// Grants one source at a time, inserts a turnaround cycle between owners and bounds hold time.
`timescale 1ns/1ps

module bus_arbiter4_rr #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       bus_en
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] MAX_C = HW'(MAX_HOLD);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    logic [1:0]    state_r, state_s;
    logic [3:0]    gnt_r, gnt_s;
    logic [1:0]    sel_r, sel_s;
    logic          bus_en_r, bus_en_s;
    logic [1:0]    ptr_r, ptr_s;
    logic [HW-1:0] hold_cnt_r, hold_cnt_s;

    logic [1:0]    winner_s;
    logic          others_s;
    logic          hold_max_s;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] oh;
        case (idx)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // First requester found scanning upward from the priority pointer, wrapping mod 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = p;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end else begin
                win   = win;
                found = found;
            end
        end
        return win;
    endfunction

    // Arbitration inputs derived from the current owner and request lines.
    always_comb begin
        winner_s   = rr_pick(req, ptr_r);
        others_s   = |(req & ~onehot4(sel_r));
        hold_max_s = (hold_cnt_r == MAX_C);
    end

    // Next-state and next-output computation for the IDLE/GRANT/TURN sequencer.
    always_comb begin
        state_s    = state_r;
        gnt_s      = gnt_r;
        sel_s      = sel_r;
        bus_en_s   = bus_en_r;
        ptr_s      = ptr_r;
        hold_cnt_s = hold_cnt_r;
        case (state_r)
            ST_IDLE, ST_TURN: begin
                if (|req) begin
                    state_s    = ST_GRANT;
                    gnt_s      = onehot4(winner_s);
                    sel_s      = winner_s;
                    bus_en_s   = 1'b1;
                    hold_cnt_s = HW'(1);
                end else begin
                    state_s    = ST_IDLE;
                    gnt_s      = 4'b0000;
                    bus_en_s   = 1'b0;
                end
            end
            ST_GRANT: begin
                // Leave on release, or on preemption once the hold budget is spent.
                if (!req[sel_r] || (hold_max_s && others_s)) begin
                    state_s  = ST_TURN;
                    gnt_s    = 4'b0000;
                    bus_en_s = 1'b0;
                    ptr_s    = sel_r + 2'd1;
                end else if (!hold_max_s) begin
                    hold_cnt_s = hold_cnt_r + HW'(1);
                end else begin
                    hold_cnt_s = hold_cnt_r;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                gnt_s    = 4'b0000;
                bus_en_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            gnt_r      <= 4'b0000;
            sel_r      <= 2'd0;
            bus_en_r   <= 1'b0;
            ptr_r      <= 2'd0;
            hold_cnt_r <= '0;
        end else begin
            state_r    <= state_s;
            gnt_r      <= gnt_s;
            sel_r      <= sel_s;
            bus_en_r   <= bus_en_s;
            ptr_r      <= ptr_s;
            hold_cnt_r <= hold_cnt_s;
        end
    end

    assign gnt    = gnt_r;
    assign sel    = sel_r;
    assign bus_en = bus_en_r;

endmodule

// File: tb/tb_bus_arbiter4_rr.sv
// Directed and randomized self-checking bench for bus_arbiter4_rr.
// Main instance uses MAX_HOLD=4; three more instances (1,3,8) share random stimulus.
`timescale 1ns/1ps

module tb_bus_arbiter4_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       bus_en;

    logic       rst_rnd;
    logic [3:0] req_rnd;
    logic [3:0] rg [3];
    logic [1:0] rs [3];
    logic       re [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_arbiter4_rr #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .sel(sel), .bus_en(bus_en)
    );
    bus_arbiter4_rr #(.MAX_HOLD(1)) dut_h1 (
        .clk(clk), .rst(rst_rnd), .req(req_rnd), .gnt(rg[0]), .sel(rs[0]), .bus_en(re[0])
    );
    bus_arbiter4_rr #(.MAX_HOLD(3)) dut_h3 (
        .clk(clk), .rst(rst_rnd), .req(req_rnd), .gnt(rg[1]), .sel(rs[1]), .bus_en(re[1])
    );
    bus_arbiter4_rr #(.MAX_HOLD(8)) dut_h8 (
        .clk(clk), .rst(rst_rnd), .req(req_rnd), .gnt(rg[2]), .sel(rs[2]), .bus_en(re[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        for (int t = 0; t < 3; t++) begin
            tick();
            checks++;
            if ({gnt, sel, bus_en} !== {4'b0000, 2'd0, 1'b0}) begin
                failures++;
                $display("FAIL reset_hold t=%0d gnt=%b sel=%0d bus_en=%b expected 0000/0/0", t, gnt, sel, bus_en);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({gnt, sel, bus_en} !== {4'b0001, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_release gnt=%b sel=%0d bus_en=%b expected 0001/0/1", gnt, sel, bus_en);
        end
    endtask

    task automatic test_full_load();
        logic [3:0] exp;
        int pos;
        int owner;
        do_reset();
        req = 4'b1111;
        for (int t = 1; t <= 21; t++) begin
            tick();
            pos   = (t - 1) % 5;
            owner = ((t - 1) / 5) % 4;
            exp   = (pos == 4) ? 4'b0000 : (4'b0001 << owner);
            checks++;
            if ({gnt, bus_en} !== {exp, |exp}) begin
                failures++;
                $display("FAIL full_load t=%0d gnt=%b bus_en=%b expected %b/%b", t, gnt, bus_en, exp, |exp);
            end
            if (pos != 4) begin
                checks++;
                if (sel !== 2'(owner)) begin
                    failures++;
                    $display("FAIL full_load_sel t=%0d sel=%0d expected %0d", t, sel, owner);
                end
            end
        end
    endtask

    task automatic test_sole();
        do_reset();
        req = 4'b0100;
        for (int t = 1; t <= 30; t++) begin
            tick();
            checks++;
            if ({gnt, sel, bus_en} !== {4'b0100, 2'd2, 1'b1}) begin
                failures++;
                $display("FAIL sole t=%0d gnt=%b sel=%0d bus_en=%b expected 0100/2/1", t, gnt, sel, bus_en);
            end
        end
    endtask

    task automatic test_early_release();
        logic [3:0] exp_g [8];
        logic [3:0] req_v [8];
        exp_g = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000};
        req_v = '{4'b1011, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b1000};
        do_reset();
        req = 4'b0001;
        for (int t = 0; t < 8; t++) begin
            tick();
            checks++;
            if ({gnt, bus_en} !== {exp_g[t], |exp_g[t]}) begin
                failures++;
                $display("FAIL early_release t=%0d gnt=%b bus_en=%b expected %b", t, gnt, bus_en, exp_g[t]);
            end
            req = req_v[t];
        end
        checks++;
        if (sel !== 2'd3) begin
            failures++;
            $display("FAIL early_release_sel sel=%0d expected 3", sel);
        end
    endtask

    task automatic test_late_preempt();
        do_reset();
        req = 4'b0001;
        for (int t = 0; t < 6; t++) tick();
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL late_preempt_own gnt=%b expected 0001", gnt);
        end
        req = 4'b0011;
        tick();
        checks++;
        if ({gnt, bus_en} !== {4'b0000, 1'b0}) begin
            failures++;
            $display("FAIL late_preempt_turn gnt=%b bus_en=%b expected 0000/0", gnt, bus_en);
        end
        tick();
        checks++;
        if ({gnt, sel} !== {4'b0010, 2'd1}) begin
            failures++;
            $display("FAIL late_preempt_next gnt=%b sel=%0d expected 0010/1", gnt, sel);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b0100;
        tick();
        tick();
        checks++;
        if ({gnt, sel} !== {4'b0100, 2'd2}) begin
            failures++;
            $display("FAIL mid_setup gnt=%b sel=%0d expected 0100/2", gnt, sel);
        end
        rst = 1'b1;
        req = 4'b1111;
        tick();
        checks++;
        if ({gnt, bus_en, sel} !== {4'b0000, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL mid_reset gnt=%b bus_en=%b sel=%0d expected 0000/0/0", gnt, bus_en, sel);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({gnt, sel, bus_en} !== {4'b0001, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL mid_after gnt=%b sel=%0d bus_en=%b expected 0001/0/1", gnt, sel, bus_en);
        end
    endtask

    task automatic test_random();
        int         maxh [3];
        int         waitc [3][4];
        logic [3:0] prev [3];
        logic [3:0] g;
        int         bound;
        maxh = '{1, 3, 8};
        rst_rnd = 1'b1;
        req_rnd = 4'b0000;
        tick();
        tick();
        rst_rnd = 1'b0;
        for (int j = 0; j < 3; j++) begin
            prev[j] = 4'b0000;
            for (int i = 0; i < 4; i++) waitc[j][i] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(5, 0) == 0) req_rnd[i] = ~req_rnd[i];
            end
            for (int j = 0; j < 3; j++) begin
                g = rg[j];
                bound = 3 * (maxh[j] + 1) + 1;
                checks++;
                if ((g & (g - 4'd1)) !== 4'b0000) begin
                    failures++;
                    $display("FAIL rnd_onehot h=%0d c=%0d gnt=%b", maxh[j], c, g);
                end
                checks++;
                if (re[j] !== (|g)) begin
                    failures++;
                    $display("FAIL rnd_bus_en h=%0d c=%0d bus_en=%b gnt=%b", maxh[j], c, re[j], g);
                end
                checks++;
                if (re[j] && (g !== (4'b0001 << rs[j]))) begin
                    failures++;
                    $display("FAIL rnd_sel h=%0d c=%0d sel=%0d gnt=%b", maxh[j], c, rs[j], g);
                end
                checks++;
                if ((prev[j] != 4'b0000 && g != 4'b0000 && g != prev[j]) !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_handover h=%0d c=%0d prev=%b gnt=%b", maxh[j], c, prev[j], g);
                end
                prev[j] = g;
                for (int i = 0; i < 4; i++) begin
                    if (req_rnd[i] && !g[i]) waitc[j][i]++;
                    else waitc[j][i] = 0;
                    checks++;
                    if (waitc[j][i] > bound) begin
                        failures++;
                        $display("FAIL rnd_starve h=%0d c=%0d src=%0d wait=%0d limit=%0d", maxh[j], c, i, waitc[j][i], bound);
                        waitc[j][i] = 0;
                    end
                end
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        req     = 4'b0000;
        rst_rnd = 1'b1;
        req_rnd = 4'b0000;
        test_reset();
        test_full_load();
        test_sole();
        test_early_release();
        test_late_preempt();
        test_reset_mid_grant();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter4_rr.md
# bus_arbiter4_rr

Round-robin arbiter and sequencer for the shared 4-source tri-state data line. The line is built from a 2-to-4 decoder driving four `bufif1` buffers. The block takes four request lines and grants the line to one owner at a time. It drives the decoder select and the global buffer enable, and inserts one idle turnaround cycle between owners so two buffers never drive the line together. It also bounds how long one owner can hold the line while others are waiting.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum number of consecutive grant cycles an owner keeps while another requester is pending. Legal range is 1 or more. The hold counter width is `$clog2(MAX_HOLD+1)`.

Ports:
- `clk`, input, 1 bit: single clock. All state updates on the rising edge.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `req`, input, 4 bits: per-source request. Level-sensitive. A source holds it high for as long as it wants the line.
- `gnt`, output, 4 bits: registered, one-hot-or-zero grant.
- `sel`, output, 2 bits: registered index of the granted source. Drives the decoder select.
- `bus_en`, output, 1 bit: registered. Equals `|gnt`. Drives the decoder enable.

## Operation
State machine with three states: IDLE, GRANT, TURN. Internal registers are `ptr[1:0]` (the highest-priority index) and `hold_cnt`.

Arbitration function, evaluated in IDLE and TURN:
- The winner is the first index i in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with `req[i]`=1.

IDLE:
- Outputs: `gnt`=0, `bus_en`=0, `sel` holds its last value.
- If `|req`, go to GRANT. Set `gnt`=onehot(winner), `sel`=winner, `hold_cnt`=1.

GRANT:
- Outputs: `bus_en`=1 and `gnt` stable.
- `hold_cnt` increments each cycle and saturates at `MAX_HOLD`.
- Exit when either condition holds:
  - `req[sel]`=0, or
  - `hold_cnt`==`MAX_HOLD` and any other `req` bit is 1 (preemption).
- On exit, go to TURN: `gnt`=0, `bus_en`=0, `ptr`=sel+1 (mod 4).
- If the owner is the only requester, it keeps the grant indefinitely. No turnaround is inserted.

TURN:
- Exactly one cycle with `gnt`=0 and `bus_en`=0.
- Apply the arbitration function with the updated `ptr`.
- If `|req`, go to GRANT (same updates as from IDLE). Otherwise go to IDLE.

Invariants:
- `gnt` is one-hot or zero.
- `bus_en`==`|gnt`.
- When `bus_en`=1, `sel` equals the index of the set `gnt` bit.
- `gnt` never changes from one nonzero value to a different nonzero value without at least one zero cycle in between.

Reset:
- `rst`=1 at an edge forces IDLE, `gnt`=0, `sel`=0, `bus_en`=0, `ptr`=0, `hold_cnt`=0, whatever the state or `req`.
- Reset mid-grant drops the line on the next edge.

## Timing
- Grant latency from IDLE: `req` sampled high at edge k gives `gnt` and `bus_en` valid after edge k.
- Release: owner `req` low at edge k gives `gnt`=0 after edge k (TURN). The next owner's `gnt` appears after edge k+1. The old owner therefore sees one extra granted cycle after dropping `req` and must tolerate it.
- Preemption:
  - The owner holds `gnt` for exactly `MAX_HOLD` cycles when others are pending from the start of the grant.
  - If another request first arrives later, preemption occurs at the first edge where that request is seen with the counter saturated.
- Handover period under full load: `MAX_HOLD`+1 cycles per owner. A full rotation of all four sources takes 4×(`MAX_HOLD`+1) cycles.
- A request arriving during TURN competes in that same cycle's arbitration.

## Test plan
- **Reset dominance:** `rst`=1 with `req`=4'b1111 for 3 cycles → `gnt`=0, `bus_en`=0, `sel`=0. Then `rst`=0 → `gnt`=4'b0001, `sel`=0 one edge later.
- **Full-load rotation, `MAX_HOLD`=4:** `req`=4'b1111 held → `gnt`=0001 for 4 cycles, 0 for 1, 0010 for 4, 0 for 1, 0100, 1000, then 0001 again 20 cycles after the first grant.
- **Sole requester:** `req`=4'b0100 held for 30 cycles → `gnt`=0100, `sel`=2, `bus_en`=1 continuously after the first edge, with no TURN cycle.
- **Early release and pointer update:**
  - Start with `req`=0001 granted. Raise `req[1]` and `req[3]`, then drop `req[0]` after 2 grant cycles.
  - Required: one TURN cycle, then `gnt`=0010.
  - After `req[1]` releases: TURN, then `gnt`=1000.
- **Reset mid-grant:** assert `rst` for 1 cycle while `gnt`=0100 → `gnt`=0 and `bus_en`=0 after that edge. With `req`=1111 afterwards, the next grant is 0001 (ptr=0).
- **Random stimulus, 10k cycles, `MAX_HOLD` in {1,3,8}:** check every invariant above each cycle, and check that no pending requester waits more than 3×(`MAX_HOLD`+1)+1 cycles.
